ppu_write_arbiter: RTL

- Collects per-core pixel write streams (data, address, valid) from the parallel pixel-computation cores and serialises them onto one framebuffer write port.
- Each core stream has no backpressure, so the block provides a small per-core FIFO and a round-robin scheduler.
- Sits between the pixel-computation array and the framebuffer memory master. The rasteriser control reads `idle` to know when a triangle's writes have fully drained.

---
 rtl/ppu_write_arbiter.sv | 123 ++++++++++++
 1 files changed

// File: rtl/ppu_write_arbiter.sv
// ppu_write_arbiter: per-core pixel FIFOs serialised round-robin onto one framebuffer write port.
// Define PPU_WRITE_ARBITER_DROP_COUNT_EN to add the saturating drop_count output.
module ppu_write_arbiter #(
    parameter int CORES_COUNT   = 10,
    parameter int COLOR_WIDTH   = 16,
    parameter int BUFFER_ADDR_W = 32,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [COLOR_WIDTH-1:0]   ppu_data    [0:CORES_COUNT-1],
    input  logic [BUFFER_ADDR_W-1:0] ppu_address [0:CORES_COUNT-1],
    input  logic [CORES_COUNT-1:0]   ppu_valid,
    output logic [BUFFER_ADDR_W-1:0] mem_address,
    output logic [COLOR_WIDTH-1:0]   mem_writedata,
    output logic                     mem_write,
    input  logic                     mem_waitrequest,
    input  logic                     clear_overflow,
    output logic [CORES_COUNT-1:0]   overflow,
    output logic                     idle
`ifdef PPU_WRITE_ARBITER_DROP_COUNT_EN
    ,
    output logic [31:0]              drop_count
`endif
);
    localparam int CW = $clog2(FIFO_DEPTH);
    localparam int RW = CORES_COUNT > 1 ? $clog2(CORES_COUNT) : 1;
    localparam logic [CW:0] FULL = (CW+1)'(FIFO_DEPTH);
    localparam logic [RW-1:0] LAST = RW'(CORES_COUNT - 1);

    logic [BUFFER_ADDR_W-1:0] fifo_addr [CORES_COUNT][FIFO_DEPTH];
    logic [COLOR_WIDTH-1:0]   fifo_data [CORES_COUNT][FIFO_DEPTH];
    logic [CW-1:0]            wr_ptr [CORES_COUNT];
    logic [CW-1:0]            rd_ptr [CORES_COUNT];
    logic [CW:0]              count  [CORES_COUNT];
    logic [RW-1:0]            rr_ptr, grant;
    logic                     found, loadable;
    logic [BUFFER_ADDR_W-1:0] sel_addr;
    logic [COLOR_WIDTH-1:0]   sel_data;
    logic [CORES_COUNT-1:0]   nonempty, pop, accept, drop;

    assign loadable = !mem_write || !mem_waitrequest;
    assign idle = !(|nonempty) && !mem_write;

    // Rotating priority search starting at rr_ptr; the head entry is picked up alongside the grant.
    always_comb begin
        int idx;
        found = 1'b0;
        grant = '0;
        sel_addr = '0;
        sel_data = '0;
        for (int k = 0; k < CORES_COUNT; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= CORES_COUNT) idx = idx - CORES_COUNT;
            if (!found && count[idx] != '0) begin
                found = 1'b1;
                grant = RW'(idx);
                sel_addr = fifo_addr[idx][rd_ptr[idx]];
                sel_data = fifo_data[idx][rd_ptr[idx]];
            end
        end
    end

    // A full FIFO still accepts when its head leaves on the same edge.
    always_comb begin
        for (int i = 0; i < CORES_COUNT; i++) begin
            nonempty[i] = count[i] != '0;
            pop[i] = loadable && found && grant == RW'(i);
            accept[i] = ppu_valid[i] && (count[i] != FULL || pop[i]);
            drop[i] = ppu_valid[i] && !accept[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_write <= 1'b0;
            mem_address <= '0;
            mem_writedata <= '0;
            rr_ptr <= '0;
            overflow <= '0;
            for (int i = 0; i < CORES_COUNT; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i] <= '0;
            end
        end else begin
            if (loadable) begin
                mem_write <= found;
                if (found) begin
                    mem_address <= sel_addr;
                    mem_writedata <= sel_data;
                    rr_ptr <= grant == LAST ? '0 : grant + 1'b1;
                end
            end
            overflow <= (clear_overflow ? '0 : overflow) | drop;
            for (int i = 0; i < CORES_COUNT; i++) begin
                if (accept[i]) begin
                    fifo_addr[i][wr_ptr[i]] <= ppu_address[i];
                    fifo_data[i][wr_ptr[i]] <= ppu_data[i];
                    wr_ptr[i] <= wr_ptr[i] + 1'b1;
                end
                if (pop[i]) rd_ptr[i] <= rd_ptr[i] + 1'b1;
                count[i] <= count[i] + (CW+1)'(accept[i]) - (CW+1)'(pop[i]);
            end
        end
    end

`ifdef PPU_WRITE_ARBITER_DROP_COUNT_EN
    logic [31:0] drop_n;
    logic [32:0] drop_sum;

    always_comb begin
        drop_n = '0;
        for (int k = 0; k < CORES_COUNT; k++) drop_n = drop_n + 32'(drop[k]);
        drop_sum = {1'b0, clear_overflow ? 32'd0 : drop_count} + {1'b0, drop_n};
    end

    always_ff @(posedge clk) begin
        if (reset) drop_count <= '0;
        else drop_count <= drop_sum[32] ? '1 : drop_sum[31:0];
    end
`endif
endmodule
